// File: rtl/batch_seq_pkg.sv
// ---------------------------------------------------------------------------
// batch_seq_pkg
// Shared types and widths for the batch sequencer and its timer.
//   state_e    : controller states (IDLE, LAUNCH, WAIT, FIN, ERR)
//   ADDR_W     : job address width
//   DATA_W     : job result width
//   SUM_W      : accumulated sum width (holds 16 x max result)
//   CNT_W      : job count width
//   clamp_jobs : min(requested, limit) for the per-batch job count
// ---------------------------------------------------------------------------
package batch_seq_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int SUM_W  = 20;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FIN,
    ERR
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_jobs(input logic [CNT_W-1:0] req,
                                                  input logic [CNT_W-1:0] limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage

// File: rtl/batch_sequencer_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Job timeout counter. Cleared to zero while the controller enters a launch,
// then counts every enabled cycle. expired_o rises once TIMEOUT cycles have
// elapsed since the launch cycle (launch cycle counts as cycle 0), and the
// counter saturates there so it never wraps.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clear_i   : force count to zero (priority over enable)
//   enable_i  : count this cycle
//   expired_o : timeout budget used up
// ---------------------------------------------------------------------------
module seq_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign expired_o = (count_q >= LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/batch_sequencer.sv
// ---------------------------------------------------------------------------
// batch_sequencer
// Runs a batch of jobs on an external compute core: launches each job with a
// one-cycle start pulse at consecutive addresses, waits for the core's finish
// rising edge, and accumulates the sum and maximum of the job results. A job
// that does not finish within TIMEOUT cycles aborts the batch into ERR.
//   clk_i           : clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   go_i            : one-cycle batch request (ignored while busy)
//   first_addr_i    : address of the first job
//   count_i         : jobs requested (clamped to MAX_JOBS, 0 = empty batch)
//   finish_i        : core job-complete level
//   out_i           : core result, valid while finish_i is high
//   start1_o        : one-cycle job launch pulse
//   start_address_o : current job address
//   busy_o          : batch in progress (LAUNCH/WAIT/FIN)
//   done_o          : one-cycle batch-complete pulse
//   err_o           : timeout abort, held until the next accepted go
//   sum_o           : sum of results in current/last batch
//   max_out_o       : max of results in current/last batch
//   jobs_done_o     : results accumulated in current/last batch
// ---------------------------------------------------------------------------
module batch_sequencer
  import batch_seq_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int MAX_JOBS = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              finish_i,
  input  logic [DATA_W-1:0] out_i,
  output logic              start1_o,
  output logic [ADDR_W-1:0] start_address_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [SUM_W-1:0]  sum_o,
  output logic [DATA_W-1:0] max_out_o,
  output logic [CNT_W-1:0]  jobs_done_o
);

  localparam logic [CNT_W-1:0] JOB_LIMIT = CNT_W'(MAX_JOBS);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0]   jobs_q, jobs_d;
  logic               finish_q;
  logic               done_q;

  logic               finish_edge;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_expired;

  // A finish level left over from the previous job must drop and rise again
  // before it counts, so only a rising edge completes a job.
  assign finish_edge = finish_i & ~finish_q;

  // The timer is zeroed on the way into LAUNCH and runs through LAUNCH and
  // WAIT, so the abort lands TIMEOUT cycles after the start pulse.
  assign timer_clear = (state_d == LAUNCH);
  assign timer_en    = (state_q == LAUNCH) || (state_q == WAIT);

  seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    max_d       = max_q;
    jobs_d      = jobs_q;
    case (state_q)
      IDLE, ERR: begin
        if (go_i) begin
          sum_d  = '0;
          max_d  = '0;
          jobs_d = '0;
          if (count_i != '0) begin
            addr_d      = first_addr_i;
            remaining_d = clamp_jobs(count_i, JOB_LIMIT);
            state_d     = LAUNCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (finish_edge) begin
          sum_d       = sum_q + SUM_W'(out_i);
          max_d       = (out_i > max_q) ? out_i : max_q;
          jobs_d      = jobs_q + CNT_W'(1);
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? FIN : LAUNCH;
        end else if (timer_expired) begin
          state_d = ERR;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      jobs_q      <= '0;
      finish_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      jobs_q      <= jobs_d;
      finish_q    <= finish_i;
      // Registered so the pulse appears with results final and busy low.
      done_q      <= (state_q == FIN);
    end
  end

  assign start1_o        = (state_q == LAUNCH);
  assign busy_o          = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == FIN);
  assign err_o           = (state_q == ERR);
  assign done_o          = done_q;
  assign start_address_o = addr_q;
  assign sum_o           = sum_q;
  assign max_out_o       = max_q;
  assign jobs_done_o     = jobs_q;

endmodule

// File: tb/tb_batch_sequencer.sv
module tb_batch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        go_i = 1'b0;
  logic [3:0]  first_addr_i = '0;
  logic [4:0]  count_i = '0;
  logic        finish_i = 1'b0;
  logic [15:0] out_i = '0;
  logic        start1_o;
  logic [3:0]  start_address_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [19:0] sum_o;
  logic [15:0] max_out_o;
  logic [4:0]  jobs_done_o;

  batch_sequencer #(.TIMEOUT(20), .MAX_JOBS(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .go_i(go_i), .first_addr_i(first_addr_i),
    .count_i(count_i), .finish_i(finish_i), .out_i(out_i), .start1_o(start1_o),
    .start_address_o(start_address_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .sum_o(sum_o), .max_out_o(max_out_o), .jobs_done_o(jobs_done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Compute core model: raises finish core_delay cycles after start1. A finish
  // still high from the previous job is first dropped, then re-raised after
  // another core_delay. In hold mode finish stays high once raised.
  int          core_delay = 5;
  bit          core_hold = 1'b0;
  int          core_silent = -1;
  logic [15:0] core_res [32];
  int          job = 0;
  int          cur_job = 0;
  int          cnt = 0;
  int          fin_left = 0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      finish_i <= 1'b0; out_i <= '0; job <= 0; cur_job <= 0; cnt <= 0; fin_left <= 0;
    end else begin
      if (fin_left == 1) finish_i <= 1'b0;
      if (fin_left > 0) fin_left <= fin_left - 1;
      if (start1_o) begin
        cnt <= (job != core_silent) ? core_delay : 0;
        cur_job <= job;
        job <= job + 1;
      end else begin
        if (!busy_o) job <= 0;
        if (cnt == 1) begin
          if (finish_i && fin_left == 0) begin
            finish_i <= 1'b0;
            cnt <= core_delay;
          end else begin
            finish_i <= 1'b1;
            out_i <= core_res[cur_job];
            fin_left <= core_hold ? 0 : 2;
            cnt <= 0;
          end
        end else if (cnt > 1) begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Monitor: logs launches, done pulses, err rise and accepted go cycles.
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         err_cyc = -1;
  int         go_cyc = -1;
  logic       err_prev = 1'b0;
  logic [3:0] addr_log [$];
  int         start_cyc [$];

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (start1_o) begin
      addr_log.push_back(start_address_o);
      start_cyc.push_back(cyc);
    end
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (err_o && !err_prev) err_cyc <= cyc;
    err_prev <= err_o;
    if (go_i && !busy_o) go_cyc <= cyc;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_go(input logic [3:0] a, input logic [4:0] n);
    first_addr_i = a;
    count_i = n;
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int bound, input string name);
    int i;
    i = 0;
    while (done_cnt == d0 && !err_o && i < bound) begin
      tick();
      i++;
    end
    checks++;
    if (done_cnt == d0 && !err_o) begin
      failures++;
      $display("FAIL %s_end: no done or err after %0d cycles, expected batch end", name, bound);
    end
  endtask

  task automatic wait_starts(input int target, input int bound, input string name);
    int i;
    i = 0;
    while (addr_log.size() < target && i < bound) begin
      tick();
      i++;
    end
    checks++;
    if (addr_log.size() < target) begin
      failures++;
      $display("FAIL %s_starts: got %0d launches expected %0d", name, addr_log.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick();
    checks++;
    if ({start1_o, busy_o, done_o, err_o, start_address_o, sum_o, max_out_o, jobs_done_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b err=%b sum=%0d jobs=%0d expected all zero",
               busy_o, err_o, sum_o, jobs_done_o);
    end
    rst_ni = 1'b1;
    tick();
    $display("test_reset: outputs cleared");
  endtask

  task automatic test_basic();
    int n0, d0;
    logic [3:0] exp_a [3];
    exp_a = '{4'd1, 4'd2, 4'd3};
    core_delay = 5; core_res[0] = 16'd10; core_res[1] = 16'd30; core_res[2] = 16'd20;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd1, 5'd3);
    wait_end(d0, 100, "basic");
    tick(); tick();
    checks++;
    if (addr_log.size() !== n0 + 3) begin failures++;
      $display("FAIL basic_launches: got %0d expected 3", addr_log.size() - n0); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_log[n0+i] !== exp_a[i]) begin failures++;
        $display("FAIL basic_addr%0d: got %0d expected %0d", i, addr_log[n0+i], exp_a[i]); end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++; if (sum_o !== 20'd60) begin failures++; $display("FAIL basic_sum: got %0d expected 60", sum_o); end
    checks++; if (max_out_o !== 16'd30) begin failures++; $display("FAIL basic_max: got %0d expected 30", max_out_o); end
    checks++; if (jobs_done_o !== 5'd3) begin failures++; $display("FAIL basic_jobs: got %0d expected 3", jobs_done_o); end
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL basic_flags: got err=%b busy=%b expected 0 0", err_o, busy_o); end
    $display("test_basic: sum=%0d max=%0d jobs=%0d", sum_o, max_out_o, jobs_done_o);
  endtask

  task automatic test_busy_go();
    int n0, d0;
    core_res[0] = 16'd100; core_res[1] = 16'd200;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd5, 5'd2);
    wait_starts(n0 + 1, 20, "busygo");
    pulse_go(4'd9, 5'd7);
    wait_end(d0, 100, "busygo");
    tick(); tick();
    checks++;
    if (addr_log.size() !== n0 + 2) begin failures++;
      $display("FAIL busygo_launches: got %0d expected 2", addr_log.size() - n0); end
    else begin
      checks++;
      if (addr_log[n0] !== 4'd5 || addr_log[n0+1] !== 4'd6) begin failures++;
        $display("FAIL busygo_addr: got %0d,%0d expected 5,6", addr_log[n0], addr_log[n0+1]); end
    end
    checks++; if (sum_o !== 20'd300) begin failures++; $display("FAIL busygo_sum: got %0d expected 300", sum_o); end
    checks++; if (jobs_done_o !== 5'd2) begin failures++; $display("FAIL busygo_jobs: got %0d expected 2", jobs_done_o); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL busygo_done: got %0d pulses expected 1", done_cnt - d0); end
    $display("test_busy_go: sum=%0d jobs=%0d", sum_o, jobs_done_o);
  endtask

  task automatic test_wrap();
    int n0, d0;
    logic [3:0] exp_a [4];
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    for (int i = 0; i < 4; i++) core_res[i] = 16'(i + 1);
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd14, 5'd4);
    wait_end(d0, 150, "wrap");
    tick();
    checks++;
    if (addr_log.size() !== n0 + 4) begin failures++;
      $display("FAIL wrap_launches: got %0d expected 4", addr_log.size() - n0); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_log[n0+i] !== exp_a[i]) begin failures++;
        $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addr_log[n0+i], exp_a[i]); end
    end
    checks++; if (sum_o !== 20'd10) begin failures++; $display("FAIL wrap_sum: got %0d expected 10", sum_o); end
    checks++; if (max_out_o !== 16'd4) begin failures++; $display("FAIL wrap_max: got %0d expected 4", max_out_o); end
    $display("test_wrap: sum=%0d max=%0d", sum_o, max_out_o);
  endtask

  task automatic test_zero_count();
    int n0, d0;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd7, 5'd0);
    wait_end(d0, 10, "zero");
    tick(); tick();
    checks++; if (addr_log.size() !== n0) begin failures++; $display("FAIL zero_launches: got %0d expected 0", addr_log.size() - n0); end
    checks++; if (done_cyc - go_cyc !== 2) begin failures++; $display("FAIL zero_latency: got %0d cycles expected 2", done_cyc - go_cyc); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL zero_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++; if ({sum_o, max_out_o, jobs_done_o} !== '0) begin failures++;
      $display("FAIL zero_results: got sum=%0d max=%0d jobs=%0d expected 0", sum_o, max_out_o, jobs_done_o); end
    $display("test_zero_count: done after %0d cycles", done_cyc - go_cyc);
  endtask

  task automatic test_clamp();
    int n0, d0;
    for (int i = 0; i < 32; i++) core_res[i] = (i < 16) ? 16'(i + 1) : 16'd999;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd0, 5'd20);
    wait_end(d0, 400, "clamp");
    tick(); tick();
    checks++; if (addr_log.size() !== n0 + 16) begin failures++; $display("FAIL clamp_launches: got %0d expected 16", addr_log.size() - n0); end
    checks++; if (jobs_done_o !== 5'd16) begin failures++; $display("FAIL clamp_jobs: got %0d expected 16", jobs_done_o); end
    checks++; if (sum_o !== 20'd136) begin failures++; $display("FAIL clamp_sum: got %0d expected 136", sum_o); end
    checks++; if (max_out_o !== 16'd16) begin failures++; $display("FAIL clamp_max: got %0d expected 16", max_out_o); end
    $display("test_clamp: jobs=%0d sum=%0d", jobs_done_o, sum_o);
  endtask

  task automatic test_hold();
    int n0, d0;
    core_hold = 1'b1;
    core_res[0] = 16'd3; core_res[1] = 16'd5; core_res[2] = 16'd9;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd2, 5'd3);
    wait_end(d0, 200, "hold");
    tick();
    core_hold = 1'b0;
    checks++;
    if (addr_log.size() !== n0 + 3) begin failures++;
      $display("FAIL hold_launches: got %0d expected 3", addr_log.size() - n0); end
    else begin
      checks++;
      if (start_cyc[n0+1] - start_cyc[n0] !== 6) begin failures++;
        $display("FAIL hold_gap1: got %0d cycles expected 6", start_cyc[n0+1] - start_cyc[n0]); end
      checks++;
      if (start_cyc[n0+2] - start_cyc[n0+1] !== 11) begin failures++;
        $display("FAIL hold_gap2: got %0d cycles expected 11", start_cyc[n0+2] - start_cyc[n0+1]); end
    end
    checks++; if (sum_o !== 20'd17) begin failures++; $display("FAIL hold_sum: got %0d expected 17", sum_o); end
    checks++; if (jobs_done_o !== 5'd3) begin failures++; $display("FAIL hold_jobs: got %0d expected 3", jobs_done_o); end
    $display("test_hold: sum=%0d jobs=%0d", sum_o, jobs_done_o);
  endtask

  task automatic test_midreset();
    int n0, d0;
    core_res[0] = 16'd10; core_res[1] = 16'd20; core_res[2] = 16'd30;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd0, 5'd3);
    wait_starts(n0 + 2, 60, "midreset");
    tick(); tick();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({start1_o, busy_o, done_o, err_o, start_address_o, sum_o, max_out_o, jobs_done_o} !== '0) begin
      failures++;
      $display("FAIL midreset_async: got busy=%b sum=%0d jobs=%0d addr=%0d expected all zero",
               busy_o, sum_o, jobs_done_o, start_address_o);
    end
    tick(); tick(); tick();
    rst_ni = 1'b1;
    tick(); tick();
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL midreset_nodone: got %0d pulses expected 0", done_cnt - d0); end
    core_res[0] = 16'd7;
    d0 = done_cnt;
    pulse_go(4'd4, 5'd1);
    wait_end(d0, 50, "afterreset");
    tick(); tick();
    checks++; if (sum_o !== 20'd7) begin failures++; $display("FAIL afterreset_sum: got %0d expected 7", sum_o); end
    checks++; if (jobs_done_o !== 5'd1) begin failures++; $display("FAIL afterreset_jobs: got %0d expected 1", jobs_done_o); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL afterreset_done: got %0d pulses expected 1", done_cnt - d0); end
    $display("test_midreset: fresh batch sum=%0d", sum_o);
  endtask

  task automatic test_timeout();
    int n0, d0;
    core_silent = 1;
    core_res[0] = 16'd40; core_res[1] = 16'd50; core_res[2] = 16'd60;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd8, 5'd3);
    wait_end(d0, 100, "timeout");
    tick(); tick(); tick(); tick(); tick();
    core_silent = -1;
    checks++;
    if (addr_log.size() !== n0 + 2) begin failures++;
      $display("FAIL timeout_launches: got %0d expected 2", addr_log.size() - n0); end
    else begin
      checks++;
      if (err_cyc - start_cyc[n0+1] !== 20) begin failures++;
        $display("FAIL timeout_latency: got %0d cycles expected 20", err_cyc - start_cyc[n0+1]); end
    end
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL timeout_flags: got err=%b busy=%b expected 1 0", err_o, busy_o); end
    checks++; if (jobs_done_o !== 5'd1) begin failures++; $display("FAIL timeout_jobs: got %0d expected 1", jobs_done_o); end
    checks++; if (sum_o !== 20'd40) begin failures++; $display("FAIL timeout_sum: got %0d expected 40", sum_o); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL timeout_nodone: got %0d pulses expected 0", done_cnt - d0); end
    $display("test_timeout: err=%0d jobs=%0d", err_o, jobs_done_o);
  endtask

  task automatic test_coincide();
    int d0;
    core_delay = 19; core_res[0] = 16'd77;
    d0 = done_cnt;
    pulse_go(4'd3, 5'd1);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL recover_err: got %0d expected 0", err_o); end
    wait_end(d0, 60, "coincide");
    tick();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL coincide_err: got %0d expected 0", err_o); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL coincide_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++; if (sum_o !== 20'd77) begin failures++; $display("FAIL coincide_sum: got %0d expected 77", sum_o); end
    $display("test_coincide: finish on last timer cycle completed, sum=%0d", sum_o);
  endtask

  task automatic test_timeout_edge();
    int n0, d0;
    core_delay = 20; core_res[0] = 16'd88;
    n0 = addr_log.size(); d0 = done_cnt;
    pulse_go(4'd3, 5'd1);
    wait_end(d0, 60, "tedge");
    tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL tedge_err: got %0d expected 1", err_o); end
    checks++; if (jobs_done_o !== 5'd0) begin failures++; $display("FAIL tedge_jobs: got %0d expected 0", jobs_done_o); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL tedge_nodone: got %0d pulses expected 0", done_cnt - d0); end
    checks++;
    if (addr_log.size() !== n0 + 1 || err_cyc - start_cyc[n0] !== 20) begin failures++;
      $display("FAIL tedge_latency: got %0d cycles expected 20", err_cyc - start_cyc[n0]); end
    $display("test_timeout_edge: err=%0d", err_o);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_busy_go();
    test_wrap();
    test_zero_count();
    test_clamp();
    test_hold();
    test_midreset();
    test_timeout();
    test_coincide();
    test_timeout_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/batch_sequencer.md
BATCH_SEQUENCER -- requirements
Module: batch_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles to wait for a job finish before abort.
REQ-002 Parameter MAX_JOBS, default 16, meaning upper clamp on jobs per batch.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 go  input  1  one-cycle batch request.
REQ-006 first_addr  input  4  start address of first job.
REQ-007 count  input  5  jobs in batch, 0..31.
REQ-008 finish  input  1  job-complete flag from the compute core, level, may stay high.
REQ-009 out  input  16  job result from the compute core, valid while finish=1.
REQ-010 start1  output  1  one-cycle job launch pulse to the compute core.
REQ-011 start_address  output  4  job address, stable from start1 until the job completes.
REQ-012 busy  output  1  batch in progress.
REQ-013 done  output  1  one-cycle batch-complete pulse.
REQ-014 err  output  1  timeout abort flag, held.
REQ-015 sum  output  20  unsigned sum of batch results.
REQ-016 max_out  output  16  unsigned max of batch results.
REQ-017 jobs_done  output  5  results accumulated in current/last batch.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT, FIN, ERR.
REQ-019 IDLE: go=1 with count!=0 latches first_addr, min(count,MAX_JOBS), clears sum/max_out/jobs_done/err, goes to LAUNCH; go=1 with count=0 clears the same and goes to FIN.
REQ-020 LAUNCH: start1=1 for exactly one cycle with start_address=current address; timer cleared; next state WAIT.
REQ-021 WAIT: job completes on the first cycle with finish=1 and finish registered low the previous cycle (rising edge); a finish high on WAIT entry does not count.
REQ-022 On completion: sum+=out (zero-extended), max_out=max(max_out,out), jobs_done+=1, address+=1 mod 16 (15 wraps to 0), remaining-=1.
REQ-023 After completion: remaining=0 goes to FIN, else LAUNCH; the next start1 is therefore 1 cycle after the finish edge.
REQ-024 WAIT timer SHALL increment each cycle; reaching TIMEOUT with no edge goes to ERR.
REQ-025 FIN: done=1 for one cycle, then IDLE; sum/max_out/jobs_done hold until next accepted go.
REQ-026 ERR: err=1, busy=0, partial sum/max_out/jobs_done hold; go accepted as in IDLE, which clears err.
REQ-027 busy=1 in LAUNCH, WAIT, FIN; 0 in IDLE and ERR.
REQ-028 go while busy=1 SHALL be ignored with no side effect.
REQ-029 A finish edge coincident with timer reaching TIMEOUT SHALL count as completion, not timeout.
REQ-030 sum SHALL not overflow: 16 x 65535 fits 20 bits.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE; start1, busy, done, err = 0; start_address, sum, max_out, jobs_done, timer, finish register = 0.
REQ-032 Reset mid-batch SHALL abandon the batch with no done pulse; after release, one go starts a fresh batch.

Structure
REQ-033 Package batch_seq_pkg SHALL hold the state enum, ADDR_W=4, DATA_W=16, SUM_W=20, CNT_W=5.
REQ-034 One sub-module seq_timer (clear, enable, TIMEOUT parameter, expired output) SHALL implement the WAIT timeout counter.

Verification
REQ-035 go, first_addr=1, count=3, core model answers 5 cycles after each start1 with out=10,30,20 -> start_address 1,2,3; done once; sum=60, max_out=30, jobs_done=3, err=0.
REQ-036 first_addr=14, count=4 -> start_address sequence 14,15,0,1.
REQ-037 count=0 -> no start1; done 2 cycles after go; sum=0, jobs_done=0.
REQ-038 TIMEOUT=20, core never asserts finish on job 2 of 3 -> err=1 at 20 cycles after second start1; busy=0; jobs_done=1; no done.
REQ-039 finish held high from the previous job into WAIT -> no completion until finish drops and rises again.
REQ-040 rst low during WAIT of job 2 -> all outputs 0 immediately; new go, count=1, out=7 -> sum=7, done pulses once.
